mips32_trace_buffer: RTL and testbench
======================================

# mips32_trace_buffer

Synthesizable instruction-trace capture unit for the mips32 single-cycle core. It replaces print-based signal monitoring with an on-chip circular buffer. Each retired instruction's PC, instruction word and control-signal bundle is recorded until a programmable trigger fires. A fixed number of post-trigger samples is then captured, the buffer freezes, and it is read out oldest-first. It sits beside the core, tapping `ProgramCounter`, `instruction` and the decoded control bundle.

## Interface
- `DEPTH`, 16: entries in the circular buffer; power of two, ≥4.
- `POST_TRIG`, 4: samples captured after the trigger sample; must be ≤ DEPTH-1.
- `CTRL_W`, 16: width of the control bundle (eq, les, upper, RegDst … Jump, Jal).
- `TS_W`, 16: timestamp width (used only with `TRACE_TIMESTAMP_EN`).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state except buffer RAM contents.
- `valid` in 1: one instruction retires this cycle; sample is eligible for capture.
- `pc` in 32: ProgramCounter of the retiring instruction.
- `instruction` in 32: instruction word.
- `ctrl` in CTRL_W: control bundle.
- `arm` in 1: one-cycle pulse; clears the buffer and starts capture.
- `trig_mode` in 2: 0 = immediate (first valid sample), 1 = opcode match, 2 = PC match, 3 = opcode or PC.
- `trig_opcode` in 6: compared with `instruction[31:26]`.
- `trig_pc` in 32: compared with `pc`.
- `rd_idx` in log2(DEPTH): readout index; 0 = oldest entry.
- `rd_data` out 64+CTRL_W (+TS_W): `{[ts,] ctrl, pc, instruction}` at `rd_idx`.
- `busy` out 1: in PRE or POST.
- `triggered` out 1: trigger has fired since the last arm.
- `done` out 1: capture frozen.
- `count` out log2(DEPTH)+1: valid entries, saturating at DEPTH.
- `trig_index` out log2(DEPTH): readout index of the trigger sample.

## Operation
- FSM states: IDLE, PRE, POST, DONE.
  - IDLE→PRE on `arm`.
  - PRE→POST when a trigger hits on a valid sample.
  - POST→DONE when the POST_TRIG-th post sample is written.
  - DONE→PRE on `arm`.
- `arm` in any state, including PRE and POST, clears `wr_ptr`, `count`, `triggered` and the post counter, then enters PRE. `arm` has priority over a coincident trigger or sample.
- Capture happens only when `valid` is high in PRE or POST.
  - Write at `wr_ptr`; `wr_ptr` wraps modulo DEPTH.
  - `count` increments and saturates at DEPTH.
  - Cycles with `valid` low write nothing and advance nothing.
- Trigger:
  - Evaluated only in PRE, on the same sample that is written.
  - The trigger sample is stored, and `trig_ptr` latches its address.
  - With POST_TRIG = 0, PRE goes directly to DONE.
- Readout:
  - Physical address = (`wr_ptr` − `count` + `rd_idx`) mod DEPTH.
  - `trig_index` = (`trig_ptr` − (`wr_ptr` − `count`)) mod DEPTH.
  - Readout is defined only in DONE. `rd_idx` ≥ `count` returns undefined data.
- Oldest entries are overwritten silently once `count` = DEPTH.

## Timing
- Reset values: `busy`=0, `triggered`=0, `done`=0, `count`=0, `trig_index`=0, `rd_data`=0; FSM in IDLE.
- A sample presented in cycle N is visible in `count` at cycle N+1.
- `triggered` rises the cycle after the trigger sample.
- `done` rises the cycle after the last post sample; `busy` falls in the same cycle.
- `rd_data` is registered: `rd_idx` applied in cycle N gives data in cycle N+1.
- Reset asserted mid-PRE/POST returns to IDLE immediately, with no partial DONE.

## Configuration
- `TRACE_TIMESTAMP_EN` defined:
  - A free-running TS_W-bit cycle counter, reset to 0 and wrapping, is stored with each entry.
  - `rd_data` widens by TS_W, with the timestamp in the MSBs.
- `TRACE_TIMESTAMP_EN` undefined: no counter is built, and `rd_data` is 64+CTRL_W bits.

## Test plan
(DEPTH=8, POST_TRIG=3; sample k has pc=4k.)
- Reset, no arm, 10 valid samples -> `count`=0, `busy`=0, `done`=0, `rd_data`=0.
- `trig_mode`=0, arm, 5 samples -> `done`=1 after sample 3, `count`=4, `trig_index`=0, `rd_idx`=0 gives pc 0x0, sample 4 not stored.
- `trig_mode`=1, `trig_opcode`=6'b000100, beq at k=9, other samples R-type, k=0..14 -> `done` after k=12, `count`=8, `rd_idx` 0..7 give pc 0x14..0x30, `trig_index`=4.
- `trig_mode`=2, `trig_pc`=0x10, `valid` low on alternate cycles -> only valid samples stored, trigger at pc 0x10, consecutive entries differ by 4.
- `reset` mid-POST after 1 post sample -> next cycle `busy`=0, `count`=0; re-arm and re-run of the previous scenario gives identical results.
- With `TRACE_TIMESTAMP_EN`, samples on consecutive cycles -> timestamps strictly increment by 1. `arm` coincident with a trigger sample -> stays PRE, `count`=0.

Source files
------------

// File: rtl/mips32_trace_buffer.sv
// mips32_trace_buffer: circular instruction-trace capture with programmable trigger and post-trigger freeze.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle timestamp in the MSBs of each entry.
module mips32_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int CTRL_W    = 16,
    parameter int TS_W      = 16,
    localparam int AW       = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW       = 64 + CTRL_W + TS_W
`else
    localparam int EW       = 64 + CTRL_W
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic [31:0]       pc,
    input  logic [31:0]       instruction,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [5:0]        trig_opcode,
    input  logic [31:0]       trig_pc,
    input  logic [AW-1:0]     rd_idx,
    output logic [EW-1:0]     rd_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [AW:0]       count,
    output logic [AW-1:0]     trig_index
);
    typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;
    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, trig_ptr, post_cnt, oldest;
    logic [EW-1:0]   wr_data;
    logic            capture, hit, op_hit, pc_hit;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    always_ff @(posedge clock or posedge reset)
        if (reset) ts <= '0;
        else ts <= ts + TS_W'(1);
    assign wr_data = {ts, ctrl, pc, instruction};
`else
    assign wr_data = {ctrl, pc, instruction};
`endif
    assign op_hit     = instruction[31:26] == trig_opcode;
    assign pc_hit     = pc == trig_pc;
    assign hit        = trig_mode == 2'd0 ? 1'b1 : trig_mode == 2'd1 ? op_hit :
                        trig_mode == 2'd2 ? pc_hit : (op_hit | pc_hit);
    // arm wins over a coincident sample, so nothing is written on the arming cycle
    assign capture    = valid && !arm && (state == PRE || state == POST);
    assign oldest     = wr_ptr - count[AW-1:0];
    assign trig_index = trig_ptr - oldest;
    assign busy       = state == PRE || state == POST;
    assign done       = state == DONE;
    always_ff @(posedge clock)
        if (capture) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            trig_ptr  <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (state == DONE) rd_data <= mem[oldest + rd_idx];
            if (arm) begin
                state     <= PRE;
                wr_ptr    <= '0;
                count     <= '0;
                trig_ptr  <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
            end else if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count == (AW+1)'(DEPTH) ? count : count + (AW+1)'(1);
                if (state == PRE && hit) begin
                    trig_ptr  <= wr_ptr;
                    triggered <= 1'b1;
                    state     <= POST_TRIG == 0 ? DONE : POST;
                end else if (state == POST) begin
                    post_cnt <= post_cnt + AW'(1);
                    if (post_cnt == AW'(POST_TRIG - 1)) state <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_mips32_trace_buffer.sv
// tb_mips32_trace_buffer: directed and random capture runs against a queue-based model of the trace.
// Honours TRACE_TIMESTAMP_EN by folding the expected cycle stamp into each model entry.
module tb_mips32_trace_buffer;
    localparam int DEPTH = 8, POST_TRIG = 3, CTRL_W = 16, TS_W = 16, AW = 3;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = 64 + CTRL_W + TS_W;
`else
    localparam int EW = 64 + CTRL_W;
`endif
    localparam logic [31:0] RTYPE = 32'h00221820, BEQ = 32'h10220003;
    logic clock = 0, reset = 1, valid = 0, arm = 0;
    logic [31:0] pc = 0, instruction = 0, trig_pc = 0;
    logic [CTRL_W-1:0] ctrl = 0;
    logic [1:0] trig_mode = 0;
    logic [5:0] trig_opcode = 0;
    logic [AW-1:0] rd_idx = 0;
    logic [EW-1:0] rd_data;
    logic busy, triggered, done;
    logic [AW:0] count;
    logic [AW-1:0] trig_index;
    int n_assert = 0, n_fail = 0;
    logic [EW-1:0] q[$];
    bit active, trig_seen, mdone;
    int post_left, total, trig_seq, cyc;

    mips32_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .CTRL_W(CTRL_W), .TS_W(TS_W)) dut (
        .clock(clock), .reset(reset), .valid(valid), .pc(pc), .instruction(instruction), .ctrl(ctrl),
        .arm(arm), .trig_mode(trig_mode), .trig_opcode(trig_opcode), .trig_pc(trig_pc), .rd_idx(rd_idx),
        .rd_data(rd_data), .busy(busy), .triggered(triggered), .done(done), .count(count),
        .trig_index(trig_index));

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        chk("busy", busy, active);
        chk("done", done, mdone);
        chk("triggered", triggered, trig_seen);
        chk("count", count, q.size());
        if (trig_seen) chk("trig_index", trig_index, (trig_seq - (total - q.size())) % DEPTH);
    endtask

    task automatic step(input logic v, input logic [31:0] p, input logic [31:0] ins, input logic a);
        logic [EW-1:0] e;
        bit h;
        valid = v; pc = p; instruction = ins; arm = a; ctrl = CTRL_W'($urandom);
        @(posedge clock);
`ifdef TRACE_TIMESTAMP_EN
        e = {TS_W'(cyc), ctrl, p, ins};
`else
        e = {ctrl, p, ins};
`endif
        cyc++;
        h = trig_mode == 2'd0 || (trig_mode[0] && ins[31:26] == trig_opcode) || (trig_mode[1] && p == trig_pc);
        if (a) begin
            q.delete(); active = 1; trig_seen = 0; mdone = 0; total = 0;
        end else if (active && v) begin
            q.push_back(e);
            if (q.size() > DEPTH) void'(q.pop_front());
            total++;
            if (!trig_seen && h) begin
                trig_seen = 1; trig_seq = total - 1; post_left = POST_TRIG;
            end else if (trig_seen) post_left--;
            if (trig_seen && post_left == 0) begin active = 0; mdone = 1; end
        end
        #1;
        check_status();
    endtask

    task automatic do_reset();
        #2 reset = 1;
        q.delete(); active = 0; trig_seen = 0; mdone = 0; total = 0; cyc = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_count", count, 0);
        chk("rst_trig_index", trig_index, 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clock) reset = 0;
    endtask

    task automatic readout();
        for (int i = 0; i < q.size(); i++) begin
            rd_idx = AW'(i);
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 0);
            chk("rd_data", rd_data, q[i]);
        end
    endtask

    task automatic alt_run(input int last_j);
        for (int j = 0; j <= last_j; j++)
            step(j % 2 == 0, j % 2 == 0 ? 32'(4 * (j / 2)) : (32'hdead0000 | 32'(j)), RTYPE, 0);
    endtask

    initial begin
        do_reset();
        // no arm: samples are ignored
        for (int k = 0; k < 10; k++) step(1, 32'(4 * k), RTYPE, 0);
        chk("idle_rd_data", rd_data, 0);
        // immediate trigger
        trig_mode = 0;
        step(0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 32'(4 * k), RTYPE, 0);
            if (k == 3) chk("imm_done_at_3", done, 1);
        end
        chk("imm_count", count, 4);
        chk("imm_trig_index", trig_index, 0);
        readout();
        rd_idx = 0;
        step(0, 0, 0, 0);
        chk("imm_pc0", rd_data[63:32], 0);
        // opcode trigger on beq at k=9
        trig_mode = 1; trig_opcode = 6'b000100;
        step(0, 0, 0, 1);
        for (int k = 0; k <= 14; k++) step(1, 32'(4 * k), k == 9 ? BEQ : RTYPE, 0);
        chk("op_count", count, 8);
        chk("op_trig_index", trig_index, 4);
        readout();
        rd_idx = 7;
        step(0, 0, 0, 0);
        chk("op_pc7", rd_data[63:32], 32'h30);
        // PC trigger with gaps between valid samples
        trig_mode = 2; trig_pc = 32'h10;
        step(0, 0, 0, 1);
        alt_run(19);
        chk("pc_trig_index", trig_index, 4);
        readout();
        // reset mid-POST, then an identical rerun
        step(0, 0, 0, 1);
        alt_run(10);
        chk("mid_post_busy", busy, 1);
        do_reset();
        step(0, 0, 0, 1);
        alt_run(19);
        chk("rerun_trig_index", trig_index, 4);
        readout();
        // arm coincident with a trigger sample
        trig_mode = 0;
        step(1, 32'h40, RTYPE, 1);
        chk("arm_coinc_busy", busy, 1);
        chk("arm_coinc_count", count, 0);
        chk("arm_coinc_trig", triggered, 0);
        // random runs, including stray re-arms mid-capture
        for (int r = 0; r < 25; r++) begin
            trig_mode = 2'($urandom);
            trig_opcode = 6'd4;
            trig_pc = 32'(4 * $urandom_range(0, 15));
            step(0, 0, 0, 1);
            for (int c = 0; c < 40 && !mdone; c++)
                step($urandom_range(0, 3) != 0, 32'(4 * $urandom_range(0, 15)),
                     {($urandom_range(0, 5) == 0) ? 6'd4 : 6'd0, 26'($urandom)}, $urandom_range(0, 29) == 0);
            if (mdone) readout();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
